// File: rtl/fpu_result_buffer.sv
// Receive side of a fixed-latency FPU pipe: credit issue, in-flight shadow pipe, result FIFO.
// Optional protocol checker on err is enabled by defining FPU_RBUF_CHECK_EN.
module fpu_result_buffer #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    output logic             issue_ready,
    input  logic             pipe_valid,
    input  logic [WIDTH-1:0] pipe_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + LATENCY + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("fpu_result_buffer: LATENCY must be >= 1");
        end
        if (DEPTH < 1) begin : g_bad_depth
            $error("fpu_result_buffer: DEPTH must be >= 1");
        end
    endgenerate

    logic                 acc;
    logic                 arrive;
    logic                 pop;
    logic                 full;
    logic                 wr_en;
    logic [LATENCY-1:0]   sh_p;
    logic [CNT_W-1:0]     occ;
    logic [CNT_W-1:0]     inflight;
    logic [CNT_W-1:0]     credits_used;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [WIDTH-1:0]     mem [DEPTH];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        next_ptr = (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign acc          = issue && issue_ready;
    assign arrive       = sh_p[LATENCY-1];
    assign credits_used = occ + inflight;
    assign issue_ready  = credits_used < DEPTH_C;
    assign pop          = out_valid && out_ready;
    assign full         = (occ == DEPTH_C);
    // A push onto a full FIFO only lands if the head leaves in the same cycle.
    assign wr_en        = pipe_valid && (!full || pop);
    assign out_valid    = (occ != '0);
    assign out_data     = out_valid ? mem[rd_ptr] : '0;

    // Stage p0..pN: shadow of accepted issues, one token per cycle of datapath latency
    generate
        if (LATENCY == 1) begin : g_sh_one
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sh_p <= '0;
                else        sh_p <= acc;
            end
        end else begin : g_sh_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) sh_p <= '0;
                else        sh_p <= {sh_p[LATENCY-2:0], acc};
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else begin
            case ({acc, arrive})
                2'b10:   inflight <= inflight + ONE_C;
                2'b01:   inflight <= inflight - ONE_C;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            case ({wr_en, pop})
                2'b10:   occ <= occ + ONE_C;
                2'b01:   occ <= occ - ONE_C;
                default: occ <= occ;
            endcase
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (pop)   rd_ptr <= next_ptr(rd_ptr);
        end
    end

    // Result storage carries data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= pipe_data;
    end

`ifdef FPU_RBUF_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if ((pipe_valid != arrive) || (pipe_valid && full && !pop)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_result_buffer.sv
// Directed bench for fpu_result_buffer (WIDTH=32, LATENCY=4, DEPTH=8).
module tb_fpu_result_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue;
    logic        issue_ready;
    logic        pipe_valid;
    logic [31:0] pipe_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;
    logic        err;

    int tests = 0;
    int fails = 0;

`ifdef FPU_RBUF_CHECK_EN
    localparam logic ERR_ON_BAD = 1'b1;
`else
    localparam logic ERR_ON_BAD = 1'b0;
`endif

    fpu_result_buffer #(.WIDTH(32), .LATENCY(4), .DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (issue),
        .issue_ready (issue_ready),
        .pipe_valid  (pipe_valid),
        .pipe_data   (pipe_data),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .err         (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iss;
        logic        pv;
        logic [31:0] pd;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        eir;
    } vec_t;

    vec_t vecs [24];

    // Datapath model: an accepted issue returns pipe_valid 4 cycles later with a fresh tag.
    logic        echo_v [4];
    logic [31:0] echo_d [4];
    int          next_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic dp_cycle(input logic iss, input logic rdy,
                            output logic accepted, output logic popped, output logic [31:0] pdata);
        @(negedge clk);
        accepted   = iss && issue_ready;
        popped     = out_valid && rdy;
        pdata      = out_data;
        issue      = iss;
        out_ready  = rdy;
        pipe_valid = echo_v[3];
        pipe_data  = echo_v[3] ? echo_d[3] : 32'h0;
        for (int i = 3; i > 0; i--) begin
            echo_v[i] = echo_v[i-1];
            echo_d[i] = echo_d[i-1];
        end
        echo_v[0] = accepted;
        echo_d[0] = next_data;
        if (accepted) next_data++;
    endtask

    initial begin
        logic        a;
        logic        p;
        logic [31:0] d;
        int          acc_cnt;
        int          pop_cnt;
        logic [31:0] last;
        logic [31:0] exp_tail [8];

        for (int i = 0; i < 24; i++) vecs[i] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1};
        vecs[0].iss  = 1'b1;
        vecs[4].pv   = 1'b1; vecs[4].pd = 32'h3F80_0000;
        vecs[5].rdy  = 1'b1; vecs[5].ev = 1'b1; vecs[5].ed = 32'h3F80_0000;
        vecs[7].iss  = 1'b1;
        vecs[8].iss  = 1'b1;
        vecs[11].pv  = 1'b1; vecs[11].pd = 32'h4000_0000;
        vecs[12].pv  = 1'b1; vecs[12].pd = 32'hC049_0FDB; vecs[12].ev = 1'b1; vecs[12].ed = 32'h4000_0000;
        vecs[13].rdy = 1'b1; vecs[13].ev = 1'b1; vecs[13].ed = 32'h4000_0000;
        vecs[14].rdy = 1'b1; vecs[14].ev = 1'b1; vecs[14].ed = 32'hC049_0FDB;
        vecs[16].iss = 1'b1;
        vecs[17].iss = 1'b1;
        vecs[20].pv  = 1'b1; vecs[20].pd = 32'h1234_5678;
        vecs[21].pv  = 1'b1; vecs[21].pd = 32'h8765_4321; vecs[21].rdy = 1'b1;
        vecs[21].ev  = 1'b1; vecs[21].ed = 32'h1234_5678;
        vecs[22].rdy = 1'b1; vecs[22].ev = 1'b1; vecs[22].ed = 32'h8765_4321;

        for (int i = 0; i < 4; i++) begin
            echo_v[i] = 1'b0;
            echo_d[i] = 32'h0;
        end
        next_data  = 1;
        rst_n      = 1'b0;
        issue      = 1'b0;
        pipe_valid = 1'b0;
        pipe_data  = 32'h0;
        out_ready  = 1'b0;

        // Reset held 3 cycles, then idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_issue_ready", issue_ready, 1'b1);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("idle_out_valid", out_valid, 1'b0);
            chk("idle_issue_ready", issue_ready, 1'b1);
            chk("idle_err", err, 1'b0);
        end

        // Table: single op, hold under back-pressure, push+pop at occ=1
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ev);
            if (vecs[i].ev) chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].ed);
            chk($sformatf("vec%0d_issue_ready", i), issue_ready, vecs[i].eir);
            chk($sformatf("vec%0d_err", i), err, 1'b0);
            issue      = vecs[i].iss;
            pipe_valid = vecs[i].pv;
            pipe_data  = vecs[i].pd;
            out_ready  = vecs[i].rdy;
        end

        // Back-pressure: issue held, consumer stalled
        acc_cnt = 0;
        for (int c = 0; c < 16; c++) begin
            dp_cycle(1'b1, 1'b0, a, p, d);
            if (a) acc_cnt++;
        end
        chk("bp_accepts", acc_cnt, 8);
        chk("bp_issue_ready", issue_ready, 1'b0);

        // Drain after stall: 1..8 in order, credit back the cycle after first pop
        for (int k = 0; k < 8; k++) begin
            dp_cycle(1'b0, 1'b1, a, p, d);
            chk($sformatf("drain%0d_pop", k), p, 1'b1);
            chk($sformatf("drain%0d_data", k), d, k + 1);
            if (k == 0) chk("drain_ir_first", issue_ready, 1'b0);
            if (k == 1) chk("drain_ir_after", issue_ready, 1'b1);
        end
        dp_cycle(1'b0, 1'b1, a, p, d);
        chk("drain_empty", out_valid, 1'b0);

        // Streaming: one result per cycle once the pipe is full
        acc_cnt = 0;
        pop_cnt = 0;
        last    = 32'd8;
        for (int c = 0; c < 40; c++) begin
            dp_cycle(1'b1, 1'b1, a, p, d);
            if (a) acc_cnt++;
            if (c >= 6) chk($sformatf("stream%0d_pop", c), p, 1'b1);
            if (p) begin
                pop_cnt++;
                chk($sformatf("stream%0d_data", c), d, last + 1);
                last = d;
            end
        end
        for (int c = 0; c < 12; c++) begin
            dp_cycle(1'b0, 1'b1, a, p, d);
            if (p) begin
                pop_cnt++;
                chk($sformatf("tail%0d_data", c), d, last + 1);
                last = d;
            end
        end
        chk("stream_count", pop_cnt, acc_cnt);
        chk("stream_empty", out_valid, 1'b0);

        // Full FIFO with simultaneous push and pop
        next_data = 1;
        acc_cnt   = 0;
        for (int c = 0; c < 14; c++) begin
            dp_cycle(1'b1, 1'b0, a, p, d);
            if (a) acc_cnt++;
        end
        chk("full_accepts", acc_cnt, 8);
        @(negedge clk);
        chk("full_head", out_data, 32'd1);
        chk("full_ir", issue_ready, 1'b0);
        issue      = 1'b0;
        pipe_valid = 1'b1;
        pipe_data  = 32'hAA;
        out_ready  = 1'b1;
        for (int i = 0; i < 7; i++) exp_tail[i] = i + 2;
        exp_tail[7] = 32'hAA;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            pipe_valid = 1'b0;
            chk($sformatf("fullpp%0d_valid", k), out_valid, 1'b1);
            chk($sformatf("fullpp%0d_data", k), out_data, exp_tail[k]);
            if (k == 0) chk("fullpp_ir", issue_ready, 1'b0);
        end
        @(negedge clk);
        chk("fullpp_empty", out_valid, 1'b0);
        chk("fullpp_err", err, ERR_ON_BAD);
        out_ready = 1'b0;

        // Reset, then an unmatched pipe_valid
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst2_err", err, 1'b0);
        chk("rst2_out_valid", out_valid, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        pipe_valid = 1'b1;
        pipe_data  = 32'h5;
        out_ready  = 1'b1;
        @(negedge clk);
        pipe_valid = 1'b0;
        chk("inject_err", err, ERR_ON_BAD);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("sticky%0d_err", c), err, ERR_ON_BAD);
        end
        rst_n = 1'b0;
        #1;
        chk("err_cleared", err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
